// File: rtl/conv_pass_scheduler.sv
// Convolution pass scheduler: walks filters x input channels, sequencing a weight load and a compute pass for each.
// Optional abort input/aborted output enabled by defining CONV_SCHED_ABORT_EN.
module conv_pass_scheduler #(
    parameter int CNT_W = 8,
    parameter int AW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_filters,
    input  logic [CNT_W-1:0] num_in_ch,
    input  logic [4:0]       kernel_size,
    output logic             filt_en,
    output logic             filt_restart,
    input  logic             filt_done,
    output logic             compute_start,
    input  logic             compute_done,
    output logic [AW-1:0]    weight_base_addr,
    output logic [CNT_W-1:0] filter_idx,
    output logic [CNT_W-1:0] channel_idx,
    output logic             busy,
`ifdef CONV_SCHED_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_REQ, S_LOAD_WAIT, S_COMP_REQ, S_COMP_WAIT, S_ADVANCE, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_nf;
    logic [CNT_W-1:0] r_nc;
    logic [4:0]       r_ks;
    logic [CNT_W-1:0] r_fidx;
    logic [CNT_W-1:0] r_cidx;
    logic [AW-1:0]    r_addr;
    logic             r_first;
    logic             r_armed;
    logic             w_abort;
    logic             w_last_ch;
    logic             w_last_f;

`ifdef CONV_SCHED_ABORT_EN
    logic r_aborted;
    assign w_abort = abort && (r_state != S_IDLE);
    assign aborted = r_aborted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_aborted <= 1'b0;
        else     r_aborted <= w_abort;
    end
`else
    assign w_abort = 1'b0;
`endif

    assign w_last_ch = (r_cidx == r_nc - CNT_W'(1));
    assign w_last_f  = (r_fidx == r_nf - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_LOAD_REQ;
            S_LOAD_REQ:  w_next = S_LOAD_WAIT;
            // r_armed is only set after filt_done was seen low inside this wait,
            // so a level left high by the previous load can never complete it.
            S_LOAD_WAIT: if (r_armed && filt_done) w_next = S_COMP_REQ;
            S_COMP_REQ:  w_next = S_COMP_WAIT;
            S_COMP_WAIT: if (compute_done) w_next = S_ADVANCE;
            S_ADVANCE:   w_next = (w_last_ch && w_last_f) ? S_DONE : S_LOAD_REQ;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_comb begin
        busy          = (r_state != S_IDLE);
        filt_en       = (r_state == S_LOAD_REQ) && r_first;
        filt_restart  = (r_state == S_LOAD_REQ) && !r_first;
        compute_start = (r_state == S_COMP_REQ);
        done          = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nf    <= '0;
            r_nc    <= '0;
            r_ks    <= '0;
            r_fidx  <= '0;
            r_cidx  <= '0;
            r_addr  <= '0;
            r_first <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_nf    <= (num_filters == '0) ? CNT_W'(1) : num_filters;
                    r_nc    <= (num_in_ch == '0) ? CNT_W'(1) : num_in_ch;
                    r_ks    <= kernel_size;
                    r_fidx  <= '0;
                    r_cidx  <= '0;
                    r_addr  <= '0;
                    r_first <= 1'b1;
                end
                S_LOAD_REQ:  r_armed <= 1'b0;
                S_LOAD_WAIT: if (!filt_done) r_armed <= 1'b1;
                // The final pass leaves indices and address on the last values.
                S_ADVANCE: begin
                    r_first <= 1'b0;
                    if (!(w_last_ch && w_last_f)) begin
                        r_addr <= r_addr + AW'(r_ks);
                        if (w_last_ch) begin
                            r_cidx <= '0;
                            r_fidx <= r_fidx + CNT_W'(1);
                        end else begin
                            r_cidx <= r_cidx + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign weight_base_addr = r_addr;
    assign filter_idx       = r_fidx;
    assign channel_idx      = r_cidx;

endmodule
